// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small valid/ready transmit FIFO.
// Each byte is sent as a start bit, 8 data bits LSB first, and a stop bit.
// The serial line is a register that follows the FSM state one clock late.
// Because of that uniform one-clock lag, every bit is exactly DELAY_FRAMES
// clocks wide on the wire.
module uart_tx_fifo #(
    parameter int DELAY_FRAMES = 234,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       tx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [12:0]   BAUD_LAST  = 13'(DELAY_FRAMES - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_state;
    logic [12:0]   r_baud_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_tx_byte;
    logic          r_uart_tx;
    logic          r_tx_busy;

    logic          w_push;
    logic          w_pop;
    logic          w_baud_last;
    logic [1:0]    w_state_nxt;
    logic [12:0]   w_baud_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_byte_nxt;
    logic          w_line_nxt;
    logic [CW-1:0] w_count_nxt;

    // A full FIFO refuses writes; a pop in the same cycle does not open a slot early.
    assign tx_ready    = (r_count != COUNT_FULL);
    assign w_push      = tx_valid && tx_ready;
    assign w_pop       = (r_state == S_IDLE) && (r_count != COUNT_ZERO);
    assign w_baud_last = (r_baud_cnt == BAUD_LAST);
    assign uart_tx     = r_uart_tx;
    assign tx_busy     = r_tx_busy;

    // Occupancy update: a push and a pop in the same cycle cancel out.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + COUNT_ONE;
            2'b01:   w_count_nxt = r_count - COUNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage: write the incoming byte at the write pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; the pointers wrap naturally modulo the depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= COUNT_ZERO;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
        end
    end

    // Frame sequencer next-state logic: baud timing, bit count and the shift register.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_byte_nxt  = r_tx_byte;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = 13'd0;
                if (w_pop) begin
                    w_byte_nxt  = r_mem[r_rd_ptr];
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    w_baud_nxt  = 13'd0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt  = r_baud_cnt + 13'd1;
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_baud_nxt = 13'd0;
                    w_byte_nxt = {1'b0, r_tx_byte[7:1]};
                    w_bit_nxt  = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 13'd1;
                end
            end
            S_STOP: begin
                if (w_baud_last) begin
                    w_baud_nxt  = 13'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_baud_nxt  = r_baud_cnt + 13'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = 13'd0;
                w_bit_nxt   = 3'd0;
                w_byte_nxt  = 8'h00;
            end
        endcase
    end

    // Line level implied by the current state; it is registered on the next edge.
    always_comb begin
        w_line_nxt = 1'b1;
        case (r_state)
            S_START: w_line_nxt = 1'b0;
            S_DATA:  w_line_nxt = r_tx_byte[0];
            default: w_line_nxt = 1'b1;
        endcase
    end

    // Sequencer state, serial line and busy flag registers; reset idles the line high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= 13'd0;
            r_bit_cnt  <= 3'd0;
            r_tx_byte  <= 8'h00;
            r_uart_tx  <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_tx_byte  <= w_byte_nxt;
            r_uart_tx  <= w_line_nxt;
            r_tx_busy  <= (r_state != S_IDLE) || (r_count != COUNT_ZERO);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at DELAY_FRAMES=8, FIFO_DEPTH=4.
// Accepted bytes go into a scoreboard queue. A monitor decodes frames from
// uart_tx and compares each one against the head of that queue.
module tb_uart_tx_fifo;

    localparam int D     = 8;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       uart_tx;
    logic       tx_busy;

    int         errors;
    int         checks;
    int         frames_seen;
    bit         in_frame;
    logic [7:0] exp_q[$];
    int         gap_q[$];

    uart_tx_fifo #(.DELAY_FRAMES(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .uart_tx  (uart_tx),
        .tx_busy  (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one byte; the byte is expected on the line once tx_ready accepts it.
    task automatic send_byte(input logic [7:0] b, output int stalls);
        stalls = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && stalls < 1000) begin
            @(negedge clk);
            stalls++;
        end
        if (tx_ready) begin
            exp_q.push_back(b);
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %0h never accepted", b);
        end
    endtask

    task automatic end_send();
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s: drain timeout, %0d bytes still expected", name, exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    // Monitor: decode 8N1 frames, with exact bit timing, from negedge samples.
    initial begin : monitor
        int         gap;
        bit         first;
        bit         frame_ok;
        bit         aborted;
        int         bit_i;
        logic [7:0] byte_v;
        gap = 0;
        first = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                gap = 0;
                first = 1'b1;
            end else if (uart_tx === 1'b0) begin
                frames_seen++;
                gap_q.push_back(first ? -1 : gap);
                first = 1'b0;
                in_frame = 1'b1;
                frame_ok = 1'b1;
                aborted = 1'b0;
                byte_v = 8'h00;
                for (int s = 0; s < 10 * D; s++) begin
                    if (s > 0) @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    bit_i = s / D;
                    if (bit_i == 0) begin
                        if (uart_tx !== 1'b0) frame_ok = 1'b0;
                    end else if (bit_i == 9) begin
                        if (uart_tx !== 1'b1) frame_ok = 1'b0;
                    end else if ((s % D) == 0) begin
                        byte_v[bit_i-1] = uart_tx;
                    end else if (uart_tx !== byte_v[bit_i-1]) begin
                        frame_ok = 1'b0;
                    end
                end
                in_frame = 1'b0;
                gap = 0;
                if (aborted) begin
                    first = 1'b1;
                end else begin
                    check("frame_timing", {31'd0, frame_ok}, 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected none", byte_v);
                    end else begin
                        check("frame_data", {24'd0, byte_v}, {24'd0, exp_q.pop_front()});
                    end
                end
            end else begin
                gap++;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int         st;
        int         ready_high;
        int         frames_before;
        logic [7:0] b;
        errors = 0;
        checks = 0;
        frames_seen = 0;
        in_frame = 1'b0;
        reset = 1'b1;
        tx_valid = 1'b0;
        tx_data = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("reset_tx_busy", {31'd0, tx_busy}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Single byte 0x55: write at edge N, line falls after N+2
        send_byte(8'h55, st);
        check("single_stall", st, 32'd0);
        @(negedge clk);                  // after N
        tx_valid = 1'b0;
        check("single_line_n", {31'd0, uart_tx}, 32'd1);
        check("single_ready_n", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);                  // after N+1
        check("single_line_n1", {31'd0, uart_tx}, 32'd1);
        check("single_busy_n1", {31'd0, tx_busy}, 32'd1);
        @(negedge clk);                  // after N+2
        check("single_line_n2", {31'd0, uart_tx}, 32'd0);
        repeat (78) @(negedge clk);      // after N+80
        check("single_busy_n80", {31'd0, tx_busy}, 32'd1);
        repeat (3) @(negedge clk);       // after N+83
        check("single_busy_n83", {31'd0, tx_busy}, 32'd0);
        check("single_line_n83", {31'd0, uart_tx}, 32'd1);
        wait_drain("single");

        // Burst 0x01..0x06 with backpressure
        gap_q.delete();
        for (int i = 1; i <= 6; i++) begin
            b = 8'(i);
            send_byte(b, st);
            // 0x06 waits for the pop two edges after the first frame's stop bit ends
            check($sformatf("burst_stall_%0d", i), st, (i == 6) ? 32'(10 * D - 2) : 32'd0);
        end
        end_send();
        wait_drain("burst");
        check("burst_frames", gap_q.size(), 32'd6);
        for (int i = 1; i < 6; i++) begin
            if (i < gap_q.size()) check($sformatf("burst_gap_%0d", i), gap_q[i], 32'd1);
        end

        // Overflow ignore: fill, then hold 0xFF while full
        for (int i = 0; i < 5; i++) begin
            b = 8'h10 + 8'(i);
            send_byte(b, st);
            check($sformatf("fill_stall_%0d", i), st, 32'd0);
        end
        @(negedge clk);
        tx_data = 8'hFF;
        ready_high = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_ready) ready_high++;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("overflow_ready_low", ready_high, 32'd0);
        wait_drain("overflow");

        // Simultaneous push/pop: 0xA3 written on the edge that pops 0x3A
        gap_q.delete();
        send_byte(8'h3A, st);
        send_byte(8'hA3, st);
        check("pushpop_stall", st, 32'd0);
        end_send();
        check("pushpop_ready", {31'd0, tx_ready}, 32'd1);
        wait_drain("pushpop");
        check("pushpop_frames", gap_q.size(), 32'd2);
        if (gap_q.size() == 2) check("pushpop_gap", gap_q[1], 32'd1);

        // Reset mid-frame during data bit 3 of 0xC0 with two bytes queued
        send_byte(8'hC0, st);
        send_byte(8'h11, st);
        send_byte(8'h22, st);
        end_send();
        st = 0;
        while (uart_tx !== 1'b0 && st < 40) begin
            @(negedge clk);
            st++;
        end
        check("rst_frame_started", {31'd0, uart_tx}, 32'd0);
        repeat (4 * D + D / 2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_line", {31'd0, uart_tx}, 32'd1);
        check("rst_async_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_async_ready", {31'd0, tx_ready}, 32'd1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        frames_before = frames_seen;
        repeat (200) @(negedge clk);
        check("rst_no_frames", frames_seen, frames_before);
        check("rst_line_idle", {31'd0, uart_tx}, 32'd1);
        check("rst_busy_idle", {31'd0, tx_busy}, 32'd0);

        // Normal operation resumes after reset
        send_byte(8'h5A, st);
        end_send();
        wait_drain("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
